// File: rtl/intr_pkg.sv
// Shared definitions for the interrupt controller: FSM encoding, register map
// and field positions.
package intr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ASSERT  = 2'd1,
    ST_SERVICE = 2'd2
  } state_e;

  localparam logic [1:0] ADDR_CTRL = 2'd0;
  localparam logic [1:0] ADDR_PEND = 2'd1;
  localparam logic [1:0] ADDR_MODE = 2'd2;
  localparam logic [1:0] ADDR_VEC  = 2'd3;

  localparam int GEN_BIT = 8;
  localparam int VEC_W   = 3;

endpackage

// File: rtl/intr_prio_enc.sv
// Lowest-index-first priority encoder; index 0 is the most urgent request.
module intr_prio_enc
  import intr_pkg::*;
#(
  parameter int N_SRC = 6
) (
  input  logic [N_SRC-1:0] req,
  output logic             valid,
  output logic [VEC_W-1:0] id
);

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    id = '0;
    // Scan from the top down so the lowest set index is the last one written.
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (req[i]) id = VEC_W'(i);
    end
  end

  assign valid = |req;

endmodule

// File: rtl/intr_ctrl.sv
// Interrupt controller: samples device IRQs, latches edge events, masks and
// prioritises them, and runs the assert/ack/EOI handshake with the CPU.
module intr_ctrl
  import intr_pkg::*;
#(
  parameter int N_SRC = 6
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [1:0]       addr,
  input  logic             WE,
  input  logic [31:0]      Din,
  output logic [31:0]      Dout,
  input  logic [N_SRC-1:0] irq_in,
  output logic             irq_out,
  output logic [VEC_W-1:0] vec,
  input  logic             ack
);

  logic [N_SRC-1:0] sync_q, sync_d;
  logic [N_SRC-1:0] prev_q, prev_d;
  logic [N_SRC-1:0] mask_q, mask_d;
  logic [N_SRC-1:0] mode_q, mode_d;
  logic [N_SRC-1:0] edge_pend_q, edge_pend_d;
  logic             gen_q, gen_d;
  state_e           state_q, state_d;
  logic [VEC_W-1:0] vec_q, vec_d;

  logic [N_SRC-1:0] rise;
  logic [N_SRC-1:0] pending;
  logic [N_SRC-1:0] eligible;
  logic [N_SRC-1:0] ack_clr;
  logic [N_SRC-1:0] pend_clr;
  logic             enc_valid;
  logic [VEC_W-1:0] enc_id;
  logic             wr_ctrl, wr_pend, wr_mode, wr_vec;
  logic             ack_take;
  logic             unused_din;

  assign wr_ctrl = WE && (addr == ADDR_CTRL);
  assign wr_pend = WE && (addr == ADDR_PEND);
  assign wr_mode = WE && (addr == ADDR_MODE);
  assign wr_vec  = WE && (addr == ADDR_VEC);

  // Only the low byte and the gen bit of Din carry register fields.
  assign unused_din = ^Din;

  assign sync_d = irq_in;
  assign prev_d = sync_q;
  assign rise   = sync_q & ~prev_q;

  always_comb begin
    mask_d = mask_q;
    gen_d  = gen_q;
    mode_d = mode_q;
    if (wr_ctrl) begin
      mask_d = Din[N_SRC-1:0];
      gen_d  = Din[GEN_BIT];
    end
    if (wr_mode) mode_d = Din[N_SRC-1:0];
  end

  // An acknowledge consumes the edge event of the source being serviced.
  assign ack_take = ack && (state_q == ST_ASSERT);

  always_comb begin
    ack_clr = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (ack_take && (vec_q == VEC_W'(i))) ack_clr[i] = 1'b1;
    end
  end

  assign pend_clr = (wr_pend ? Din[N_SRC-1:0] : '0) | ack_clr;

  // A new rising edge wins over a clear in the same cycle; level-mode lanes
  // are held at zero so no stale event survives a mode change.
  assign edge_pend_d = ((edge_pend_q & ~pend_clr) | rise) & mode_q;

  assign pending  = (mode_q & edge_pend_q) | (~mode_q & sync_q);
  assign eligible = pending & mask_q & {N_SRC{gen_q}};

  intr_prio_enc #(
    .N_SRC (N_SRC)
  ) u_prio_enc (
    .req   (eligible),
    .valid (enc_valid),
    .id    (enc_id)
  );

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    case (state_q)
      ST_IDLE: begin
        if (enc_valid) begin
          state_d = ST_ASSERT;
          vec_d   = enc_id;
        end
      end
      ST_ASSERT: begin
        // vec tracks the best request until the CPU takes it, then freezes.
        if (ack) begin
          state_d = ST_SERVICE;
        end else if (!enc_valid) begin
          state_d = ST_IDLE;
        end else begin
          vec_d = enc_id;
        end
      end
      ST_SERVICE: begin
        if (wr_vec) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      sync_q      <= '0;
      prev_q      <= '0;
      mask_q      <= '0;
      mode_q      <= '0;
      edge_pend_q <= '0;
      gen_q       <= 1'b0;
      state_q     <= ST_IDLE;
      vec_q       <= '0;
    end else begin
      sync_q      <= sync_d;
      prev_q      <= prev_d;
      mask_q      <= mask_d;
      mode_q      <= mode_d;
      edge_pend_q <= edge_pend_d;
      gen_q       <= gen_d;
      state_q     <= state_d;
      vec_q       <= vec_d;
    end
  end

  assign irq_out = (state_q == ST_ASSERT);
  assign vec     = vec_q;

  always_comb begin
    Dout = '0;
    case (addr)
      ADDR_CTRL: begin
        Dout          = 32'(mask_q);
        Dout[GEN_BIT] = gen_q;
      end
      ADDR_PEND: Dout = 32'(pending);
      ADDR_MODE: Dout = 32'(mode_q);
      ADDR_VEC: begin
        Dout[31:30]      = state_q;
        Dout[VEC_W-1:0]  = vec_q;
      end
      default: Dout = '0;
    endcase
  end

endmodule

// File: doc/intr_ctrl.md
# intr_ctrl

Interrupt controller between the timers (and other IRQ-raising peripherals) and the CPU's exception logic. It samples up to eight device IRQ lines and latches edge-mode events. It masks and priority-encodes the lines, then presents one interrupt at a time to the CPU through an assert/ack/end-of-interrupt handshake. Software configures it through the same 2-bit-address, 32-bit register-port style used by the timers.

## Interface
- `N_SRC`, default 6: number of interrupt sources, legal range 1..8; source 0 has the highest priority.
- `clk`  input  1  system clock; all state updates on the rising edge.
- `clr`  input  1  reset, asynchronous, active-low.
- `addr`  input  2  register select: 0 CTRL, 1 PEND, 2 MODE, 3 VEC/EOI.
- `WE`  input  1  register write strobe, sampled at `clk`.
- `Din`  input  32  write data.
- `Dout`  output  32  read data, combinational from `addr`.
- `irq_in`  input  N_SRC  device requests; timer IRQ outputs connect here.
- `irq_out`  output  1  interrupt request to the CPU.
- `vec`  output  3  ID of the source currently asserted or in service.
- `ack`  input  1  CPU exception entry, one-cycle pulse.

## Operation
- Registers:
  - CTRL: [N_SRC-1:0] `mask` (1 = enabled); [8] `gen`, the global enable.
  - PEND: read returns `pending`; a write clears edge-mode pending bits wherever Din bit = 1.
  - MODE: per-source bit, 0 = level, 1 = rising edge.
  - VEC: read returns {state[1:0] at [31:30], zeros, `vec` at [2:0]}; any write is EOI.
  - All unused read bits are 0.
- Sampling:
  - `sync_q <= irq_in`, then `prev_q <= sync_q`.
  - `rise = sync_q & ~prev_q`.
- Pending:
  - Level source: `pending[i] = sync_q[i]`.
  - Edge source: set on `rise[i]`. Cleared by a PEND write-1, or by `ack` when `i == vec`.
  - If set and clear coincide, set wins.
- `eligible = pending & mask & {N_SRC{gen}}`. The priority encoder selects the lowest set index.
- FSM states: IDLE=0, ASSERT=1, SERVICE=2.
  - IDLE → ASSERT when `eligible != 0`; `vec` loads the encoder output.
  - ASSERT: `vec` re-evaluates every cycle to the current highest eligible source.
  - ASSERT → IDLE if `eligible == 0` (the request was withdrawn or masked).
  - ASSERT → SERVICE on `ack`; `vec` freezes.
  - SERVICE → IDLE on an EOI write. No nesting: further requests stay pending.
- `irq_out = (state == ASSERT)`.
- `ack` outside ASSERT and EOI outside SERVICE are ignored.
- Reset state: mask, gen, mode, pending, sync_q, prev_q all 0; state IDLE; `vec`=0; `irq_out`=0; `Dout` reflects the reset registers.

## Timing
- Level source, `irq_in` high before edge k:
  - `sync_q` = 1 after edge k.
  - ASSERT and `irq_out`=1 after edge k+1.
- Edge source, same stimulus:
  - pending = 1 after edge k+1.
  - `irq_out`=1 after edge k+2.
- `ack` sampled at edge m: SERVICE and `irq_out`=0 after edge m.
- An EOI at edge e with a source still eligible: IDLE after e, ASSERT after e+1. This gives a minimum one-cycle `irq_out` gap.
- Register writes take effect at the writing edge. A CTRL write that empties `eligible` during ASSERT causes IDLE at the next edge.
- WE and `ack` in the same cycle: both are applied. A PEND write-1 to `vec` plus `ack` still enters SERVICE.
- Asynchronous `clr` mid-handshake: immediate IDLE and `irq_out`=0; all pending events are lost.

## Structure
- Package `intr_pkg`:
  - state encoding IDLE/ASSERT/SERVICE;
  - register address constants CTRL/PEND/MODE/VEC;
  - the `gen` bit position (8);
  - the vec width (3).
- Sub-module `intr_prio_enc`: combinational, N_SRC-wide lowest-index-first encoder with `valid` and 3-bit `id` outputs.
- Everything else is in `intr_ctrl`.

## Test plan
- Reset → `irq_out`=0, CTRL/PEND/MODE/VEC all read 0. Pulse `clr` low during SERVICE → state returns to 0 immediately.
- CTRL=0x13F, MODE=0, then raise `irq_in[2]` → `irq_out` high 2 cycles later with `vec`=2. Pulse `ack` → `irq_out` low and VEC reads 0x80000002. EOI write → state IDLE.
- MODE=0x01, pulse `irq_in[0]` for 1 cycle with `irq_out` suppressed (gen=0) → PEND reads 0x01. Write PEND=0x01 → PEND reads 0. Set gen=1 → no `irq_out`.
- Raise `irq_in[4]`; once ASSERT, raise `irq_in[1]` → `vec` changes 4→1 before `ack`. `ack` → `vec` frozen at 1. EOI → re-asserts with `vec`=4 after a one-cycle gap.
- During ASSERT with `vec`=3, write CTRL=0x100 → `irq_out` drops the next cycle. A later `ack` is ignored and the state stays IDLE.
- Edge source 5: a `rise` in the same cycle as its `ack` → SERVICE entered and PEND bit 5 stays 1.
